// File: rtl/id_pkg.sv
// Shared types and encodings for the pipelined decode stage.
package id_pkg;

  // Control bundle carried from ID to EX
  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jal;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_LUI = 4'h7;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode/funct decoder; unknown encodings decode as a NOP.
module id_ctrl_decode
  import id_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_c,
  output logic       reg_dst_c,
  output logic       alu_src_c,
  output logic       ext_op_c,
  output logic       imm_zero_c,
  output logic       uses_rt_c
);

  // Opcode table with all-zero defaults
  always_comb begin
    ctrl_c     = '0;
    reg_dst_c  = 1'b0;
    alu_src_c  = 1'b0;
    ext_op_c   = 1'b0;
    imm_zero_c = 1'b0;
    uses_rt_c  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        reg_dst_c     = 1'b1;
        uses_rt_c     = 1'b1;
        imm_zero_c    = 1'b1;
        ctrl_c.reg_wr = 1'b1;
        case (funct_i)
          FN_ADD, FN_ADDU: ctrl_c.alu_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_c.alu_ctrl = ALU_SUB;
          FN_AND:          ctrl_c.alu_ctrl = ALU_AND;
          FN_OR:           ctrl_c.alu_ctrl = ALU_OR;
          FN_XOR:          ctrl_c.alu_ctrl = ALU_XOR;
          FN_NOR:          ctrl_c.alu_ctrl = ALU_NOR;
          FN_SLT:          ctrl_c.alu_ctrl = ALU_SLT;
          default:         ctrl_c          = '0;
        endcase
      end
      OP_J: begin
        imm_zero_c   = 1'b1;
        ctrl_c.jump  = 1'b1;
      end
      OP_JAL: begin
        imm_zero_c    = 1'b1;
        ctrl_c.reg_wr = 1'b1;
        ctrl_c.jump   = 1'b1;
        ctrl_c.jal    = 1'b1;
      end
      OP_BEQ: begin
        uses_rt_c       = 1'b1;
        ext_op_c        = 1'b1;
        ctrl_c.branch   = 1'b1;
        ctrl_c.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        alu_src_c       = 1'b1;
        ext_op_c        = 1'b1;
        ctrl_c.reg_wr   = 1'b1;
        ctrl_c.alu_ctrl = ALU_ADD;
      end
      OP_ANDI: begin
        alu_src_c       = 1'b1;
        ctrl_c.reg_wr   = 1'b1;
        ctrl_c.alu_ctrl = ALU_AND;
      end
      OP_LUI: begin
        alu_src_c       = 1'b1;
        ctrl_c.reg_wr   = 1'b1;
        ctrl_c.alu_ctrl = ALU_LUI;
      end
      OP_LW: begin
        alu_src_c         = 1'b1;
        ext_op_c          = 1'b1;
        ctrl_c.reg_wr     = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        alu_src_c       = 1'b1;
        ext_op_c        = 1'b1;
        uses_rt_c       = 1'b1;
        ctrl_c.mem_wr   = 1'b1;
        ctrl_c.alu_ctrl = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: GPR file with WB bypass, operand build, load-use
// hazard detection and a registered ID/EX output with stall and flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc4,
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     ex_mem_to_reg,
  input  logic [$clog2(NREG)-1:0]  ex_rd,
  input  logic                     ex_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_opa,
  output logic [XLEN-1:0]          out_opb,
  output logic [XLEN-1:0]          out_rt_data,
  output logic [$clog2(NREG)-1:0]  out_rd,
  output ctrl_t                    out_ctrl
);

  localparam int unsigned RW    = $clog2(NREG);
  localparam int unsigned EXT_W = XLEN - IMM_W;

  logic [RW-1:0]    rs, rt, rd;
  logic [XLEN-1:0]  gpr_q [NREG];
  logic [XLEN-1:0]  rs_data, rt_data;
  logic [IMM_W-1:0] imm_raw;
  logic [XLEN-1:0]  ext_imm, opa, opb;
  logic [RW-1:0]    dst;
  ctrl_t            dec_ctrl;
  logic             reg_dst, alu_src, ext_op, imm_zero, uses_rt;
  logic             hz, load_en, accept;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  opa_q, opa_d, opb_q, opb_d, rtd_q, rtd_d;
  logic [RW-1:0]    rd_q, rd_d;
  ctrl_t            ctrl_q, ctrl_d;

  assign rs = RW'(in_instr[25:21]);
  assign rt = RW'(in_instr[20:16]);
  assign rd = RW'(in_instr[15:11]);

  id_ctrl_decode u_dec (
    .opcode_i   (in_instr[31:26]),
    .funct_i    (in_instr[5:0]),
    .ctrl_c     (dec_ctrl),
    .reg_dst_c  (reg_dst),
    .alu_src_c  (alu_src),
    .ext_op_c   (ext_op),
    .imm_zero_c (imm_zero),
    .uses_rt_c  (uses_rt)
  );

  // GPR file; r0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_q <= '{default: '0};
    end else if (wb_we && (wb_rd != '0)) begin
      gpr_q[wb_rd] <= wb_data;
    end
  end

  // Register reads with same-cycle write-through from WB
  always_comb begin
    rs_data = gpr_q[rs];
    rt_data = gpr_q[rt];
    if (rs == '0)                         rs_data = '0;
    else if (wb_we && (wb_rd == rs))      rs_data = wb_data;
    if (rt == '0)                         rt_data = '0;
    else if (wb_we && (wb_rd == rt))      rt_data = wb_data;
  end

  // Immediate extension, operand and destination selection
  always_comb begin
    imm_raw = imm_zero ? '0 : in_instr[IMM_W-1:0];
    ext_imm = ext_op ? {{EXT_W{imm_raw[IMM_W-1]}}, imm_raw}
                     : {{EXT_W{1'b0}}, imm_raw};
    opa     = dec_ctrl.jal ? in_pc4 : rs_data;
    opb     = alu_src ? ext_imm : rt_data;
    dst     = dec_ctrl.jal ? RW'(LINK_REG) : (reg_dst ? rd : rt);
  end

  // Load-use hazard against the load in EX, and the IF handshake
  assign hz       = in_valid & ex_mem_to_reg & (ex_rd != '0) &
                    ((ex_rd == rs) | ((ex_rd == rt) & uses_rt));
  assign load_en  = ~valid_q | ex_ready;
  assign accept   = load_en & in_valid & ~hz & ~flush;
  assign in_ready = flush | (load_en & ~hz);

  // ID/EX next state: flush kills, otherwise load or bubble when free
  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rtd_d   = rtd_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = accept;
    end
    if (accept) begin
      opa_d  = opa;
      opb_d  = opb;
      rtd_d  = rt_data;
      rd_d   = dst;
      ctrl_d = dec_ctrl;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rtd_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rtd_q   <= rtd_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opa     = opa_q;
  assign out_opb     = opb_q;
  assign out_rt_data = rtd_q;
  assign out_rd      = rd_q;
  assign out_ctrl    = ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc4 = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_mem_to_reg = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_ready = 1'b1;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_opa, out_opb, out_rt_data;
  logic [4:0]  out_rd;
  ctrl_t       out_ctrl;
  logic [9:0]  ctrl_bits;

  assign ctrl_bits = out_ctrl;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc4        (in_pc4),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rd         (ex_rd),
    .ex_ready      (ex_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_opa       (out_opa),
    .out_opb       (out_opb),
    .out_rt_data   (out_rt_data),
    .out_rd        (out_rd),
    .out_ctrl      (out_ctrl)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk(input logic rw, input logic mw, input logic mr,
                                    input logic br, input logic j, input logic jl,
                                    input logic [3:0] alu);
    return {rw, mw, mr, br, j, jl, alu};
  endfunction

  // What the stage must produce for one instruction, given its register values
  task automatic model_decode(input logic [31:0] instr, input logic [31:0] pc4,
                              input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] opa, output logic [31:0] opb,
                              output logic [4:0] rd, output logic [9:0] ctrl,
                              output logic uses_rt);
    logic [15:0] imm;
    logic [31:0] sx, zx;
    imm = instr[15:0];
    sx  = {{16{imm[15]}}, imm};
    zx  = {16'h0000, imm};
    opa = a; opb = b; rd = instr[20:16]; ctrl = '0; uses_rt = 1'b0;
    case (instr[31:26])
      6'h00: begin
        uses_rt = 1'b1;
        rd = instr[15:11];
        case (instr[5:0])
          6'h20, 6'h21: ctrl = mk(1, 0, 0, 0, 0, 0, 4'd0);
          6'h22, 6'h23: ctrl = mk(1, 0, 0, 0, 0, 0, 4'd1);
          6'h24:        ctrl = mk(1, 0, 0, 0, 0, 0, 4'd2);
          6'h25:        ctrl = mk(1, 0, 0, 0, 0, 0, 4'd3);
          6'h26:        ctrl = mk(1, 0, 0, 0, 0, 0, 4'd4);
          6'h27:        ctrl = mk(1, 0, 0, 0, 0, 0, 4'd5);
          6'h2A:        ctrl = mk(1, 0, 0, 0, 0, 0, 4'd6);
          default:      ctrl = '0;
        endcase
      end
      6'h02: ctrl = mk(0, 0, 0, 0, 1, 0, 4'd0);
      6'h03: begin ctrl = mk(1, 0, 0, 0, 1, 1, 4'd0); opa = pc4; rd = 5'd31; end
      6'h04: begin ctrl = mk(0, 0, 0, 1, 0, 0, 4'd1); uses_rt = 1'b1; end
      6'h08: begin ctrl = mk(1, 0, 0, 0, 0, 0, 4'd0); opb = sx; end
      6'h0C: begin ctrl = mk(1, 0, 0, 0, 0, 0, 4'd2); opb = zx; end
      6'h0F: begin ctrl = mk(1, 0, 0, 0, 0, 0, 4'd7); opb = zx; end
      6'h23: begin ctrl = mk(1, 0, 1, 0, 0, 0, 4'd0); opb = sx; end
      6'h2B: begin ctrl = mk(0, 1, 0, 0, 0, 0, 4'd0); opb = sx; uses_rt = 1'b1; end
      default: ;
    endcase
  endtask

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_opa = '0, m_opb = '0, m_rt = '0;
  logic [4:0]  m_rd = '0;
  logic [9:0]  m_ctrl = '0;

  function automatic logic hazard(input logic u);
    return in_valid && ex_mem_to_reg && (ex_rd != 5'd0) &&
           ((ex_rd == in_instr[25:21]) || ((ex_rd == in_instr[20:16]) && u));
  endfunction

  // Model update on every clock edge or reset assertion
  initial begin
    logic [31:0] a, b, e_opa, e_opb;
    logic [4:0]  e_rd;
    logic [9:0]  e_ctrl;
    logic        u;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0; m_opa = '0; m_opb = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
      end else begin
        // a write-through read sees the value WB writes this cycle
        if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        a = m_regs[in_instr[25:21]];
        b = m_regs[in_instr[20:16]];
        model_decode(in_instr, in_pc4, a, b, e_opa, e_opb, e_rd, e_ctrl, u);
        if (flush) begin
          m_valid = 1'b0;
        end else if (!m_valid || ex_ready) begin
          m_valid = in_valid && !hazard(u);
          if (m_valid) begin
            m_opa = e_opa; m_opb = e_opb; m_rt = b; m_rd = e_rd; m_ctrl = e_ctrl;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    logic [31:0] d0, d1;
    logic [4:0]  d2;
    logic [9:0]  d3;
    logic        u, exp_ready;
    forever begin
      @(negedge clk);
      model_decode(in_instr, in_pc4, '0, '0, d0, d1, d2, d3, u);
      exp_ready = flush || ((!m_valid || ex_ready) && !hazard(u));
      check("cmp_in_ready", 32'(in_ready), 32'(exp_ready));
      check("cmp_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("cmp_opa", out_opa, m_opa);
        check("cmp_opb", out_opb, m_opb);
        check("cmp_rt_data", out_rt_data, m_rt);
        check("cmp_rd", 32'(out_rd), 32'(m_rd));
        check("cmp_ctrl", 32'(ctrl_bits), 32'(m_ctrl));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10];
    logic [5:0] fns [10];
    logic [5:0] op;
    logic [15:0] low;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F};
    op  = ops[$urandom_range(0, 9)];
    if (op == 6'h00)
      low = {5'($urandom_range(0, 7)), 5'($urandom), fns[$urandom_range(0, 9)]};
    else
      low = 16'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), low};
  endfunction

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_opa", out_opa, 32'h0);
    check("rst_opb", out_opb, 32'h0);
    check("rst_rt", out_rt_data, 32'h0);
    check("rst_rd", 32'(out_rd), 32'h0);
    check("rst_ctrl", 32'(ctrl_bits), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // r5 = 0x1234, then ADDI r6, r5, -1
    tick(); reset = 1'b0; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    tick(); wb_we = 1'b0; in_valid = 1'b1; in_instr = itype(6'h08, 5'd5, 5'd6, 16'hFFFF);
    @(negedge clk);
    check("addi_ready", 32'(in_ready), 32'h1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("addi_valid", 32'(out_valid), 32'h1);
    check("addi_opa", out_opa, 32'h0000_1234);
    check("addi_opb", out_opb, 32'hFFFF_FFFF);
    check("addi_rd", 32'(out_rd), 32'd6);
    check("addi_ctrl", 32'(ctrl_bits), 32'h200);

    // r0 write ignored, ANDI zero-extends
    tick(); wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    tick(); in_valid = 1'b1; in_instr = itype(6'h0C, 5'd0, 5'd8, 16'h8000);
    tick(); in_valid = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("andi_opa", out_opa, 32'h0);
    check("andi_opb", out_opb, 32'h0000_8000);

    // same-cycle bypass into an R-type add r9, r7, r0
    tick(); wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
    in_valid = 1'b1; in_instr = {6'h00, 5'd7, 5'd0, 5'd9, 5'd0, 6'h20};
    tick(); in_valid = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    check("byp_opa", out_opa, 32'h0000_CAFE);
    check("byp_rd", 32'(out_rd), 32'd9);
    check("byp_ctrl", 32'(ctrl_bits), 32'h200);

    // load-use: SW r3 -> 16(r1) while EX loads r3
    tick(); ex_mem_to_reg = 1'b1; ex_rd = 5'd3;
    in_valid = 1'b1; in_instr = itype(6'h2B, 5'd1, 5'd3, 16'h0010);
    @(negedge clk);
    check("lu_ready", 32'(in_ready), 32'h0);
    tick();
    @(negedge clk);
    check("lu_bubble", 32'(out_valid), 32'h0);
    tick(); ex_mem_to_reg = 1'b0;
    @(negedge clk);
    check("lu_ready2", 32'(in_ready), 32'h1);

    // back-pressure for three cycles, then flush
    tick(); ex_ready = 1'b0; in_instr = itype(6'h08, 5'd0, 5'd2, 16'h0005);
    @(negedge clk);
    check("sw_valid", 32'(out_valid), 32'h1);
    check("sw_ctrl", 32'(ctrl_bits), 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_opb", out_opb, 32'h0000_0010);
      check("bp_rd", 32'(out_rd), 32'd3);
      check("bp_ready", 32'(in_ready), 32'h0);
    end
    tick(); flush = 1'b1;
    @(negedge clk);
    check("fl_ready", 32'(in_ready), 32'h1);
    tick(); flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    check("fl_valid", 32'(out_valid), 32'h0);

    // JAL links to r31 with the PC+4 as operand A
    tick(); in_valid = 1'b1; in_instr = {6'h03, 26'h0000010}; in_pc4 = 32'h0000_0040;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check("jal_rd", 32'(out_rd), 32'd31);
    check("jal_opa", out_opa, 32'h0000_0040);
    check("jal_ctrl", 32'(ctrl_bits), 32'h230);

    // reset in the middle of a stalled transfer
    tick(); in_valid = 1'b1; in_instr = itype(6'h08, 5'd0, 5'd4, 16'h0001); ex_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_opa", out_opa, 32'h0);
    tick(); reset = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;

    // randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      tick();
      in_valid      = ($urandom_range(0, 9) < 7);
      in_instr      = rand_instr();
      in_pc4        = $urandom;
      wb_we         = ($urandom_range(0, 9) < 4);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      ex_mem_to_reg = ($urandom_range(0, 9) < 3);
      ex_rd         = 5'($urandom_range(0, 7));
      ex_ready      = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
    end
    tick();
    in_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1; ex_mem_to_reg = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised, pipelined successor to the single-cycle decode stage. It accepts instructions from IF over a valid/ready handshake and reads an internal GPR file with write-through bypass from WB. It builds the extended immediate and operand B, detects load-use hazards against EX, and holds the result in a registered ID/EX output with valid, stall and flush support. It sits between the IF stage and the EX stage.

Parameters:
XLEN, 32, datapath and register width (>=16)
NREG, 32, number of GPRs (power of two; index width RW = log2(NREG); reg 0 reads as zero, writes ignored)
IMM_W, 16, immediate field width (IMM_W < XLEN)
LINK_REG, 31, destination register for JAL

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  IF presents an instruction
in_ready  out  1  ID can accept this cycle
in_instr  in  32  instruction word
in_pc4  in  XLEN  PC+4 of the instruction (JAL link value)
wb_we  in  1  WB write enable
wb_rd  in  RW  WB destination
wb_data  in  XLEN  WB data
ex_mem_to_reg  in  1  instruction currently in EX is a load
ex_rd  in  RW  destination of the instruction in EX
ex_ready  in  1  EX accepts the ID/EX register this cycle
flush  in  1  kill the held and the incoming instruction (branch/jump taken)
out_valid  out  1  ID/EX register holds a valid instruction
out_opa  out  XLEN  operand A
out_opb  out  XLEN  operand B (immediate or rt data)
out_rt_data  out  XLEN  rt data (store data)
out_rd  out  RW  resolved destination (rd, rt, or LINK_REG)
out_ctrl  out  ctrl_t width  packed control: reg_wr, mem_wr, mem_to_reg, branch, jump, jal, alu_ctrl[3:0]

Behaviour:
- Reset (async, active-high): out_valid=0, out_opa/out_opb/out_rt_data=0, out_rd=0, out_ctrl=0, all GPRs=0. in_ready is combinational and is 1 during reset deassertion.
- Fields: opcode=in_instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[IMM_W-1:0].
- GPR write: on the clk edge when wb_we and wb_rd!=0. Read bypass: if wb_we and wb_rd==rs (or rt) and the index is non-zero, the read returns wb_data in the same cycle.
- Immediate: if imm_zero, imm=0. Extension is sign if ext_op, otherwise zero, from IMM_W to XLEN. opb = alu_src ? ext_imm : rt_data. For jal, opa=in_pc4.
- Destination: jal -> LINK_REG; else reg_dst ? rd : rt.
- Hazard: hz = in_valid & ex_mem_to_reg & ex_rd!=0 & (ex_rd==rs | (ex_rd==rt & uses_rt)). uses_rt is 1 for R-type, SW and BEQ.
- in_ready = (~out_valid | ex_ready) & ~hz.
- Capture: the ID/EX register loads when (~out_valid | ex_ready). On load, out_valid = in_valid & ~hz & ~flush. When hz holds, a bubble is inserted (out_valid=0) and IF is held; the instruction is re-read next cycle.
- If out_valid & ~ex_ready, all outputs hold stable and in_ready=0.
- flush: out_valid clears at the next edge regardless of ex_ready. The incoming instruction is dropped and in_ready is forced to 1 that cycle. flush has priority over hz and capture.
- Latency: 1 cycle from the in_valid&in_ready edge to out_valid.
- Unknown opcode: decoded as NOP (all ctrl 0). out_valid still follows the handshake.
- Reset mid-stall clears out_valid immediately. Stalled state is not retained.

Decomposition:
- Package id_pkg:
  - ctrl_t packed struct
  - opcode constants: OP_RTYPE 6'h00, OP_J 6'h02, OP_JAL 6'h03, OP_BEQ 6'h04, OP_ADDI 6'h08, OP_ANDI 6'h0C, OP_LUI 6'h0F, OP_LW 6'h23, OP_SW 6'h2B
  - ALU codes
- Sub-module id_ctrl_decode: purely combinational, opcode/funct -> ctrl_t plus reg_dst, alu_src, ext_op, imm_zero, uses_rt.
- GPR array inline.

Test Plan:
- After reset, WB writes r5=32'h0000_1234, then ADDI rt=6 rs=5 imm=16'hFFFF -> one cycle later out_opa=32'h1234, out_opb=32'hFFFF_FFFF, out_rd=6, reg_wr=1, out_valid=1.
- ANDI with imm 16'h8000 -> out_opb=32'h0000_8000 (zero-ext). wb_we to r0 with 32'hDEAD, then read r0 -> out_opa=0.
- Same-cycle bypass: wb_we r7=32'hCAFE while an R-type instruction with rs=7 is accepted -> out_opa=32'hCAFE.
- Load-use: ex_mem_to_reg=1, ex_rd=3, incoming SW with rt=3 -> in_ready=0, out_valid=0 for one edge. With ex_mem_to_reg=0 on the next cycle -> instruction accepted, out_valid=1.
- Back-pressure: ex_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. Then flush=1 -> out_valid=0 at the next edge and in_ready=1.
- JAL with in_pc4=32'h0000_0040 -> out_rd=31, out_opa=32'h40, jal=1, jump=1. Asserting reset mid-transfer -> out_valid=0 asynchronously.
